// File: rtl/uart_pkg.sv
// Shared UART definitions: RX state encoding, parity type and prescale constants,
// plus small bit-level helpers used by both the RX and TX paths.
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_e;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  localparam int unsigned PRESCALE_8  = 32'd8;
  localparam int unsigned PRESCALE_16 = 32'd16;
  localparam int unsigned PRESCALE_32 = 32'd32;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Odd parity is the even-parity bit inverted.
  function automatic logic parity_expect(input logic data_xor, input logic parity_type);
    return data_xor ^ (parity_type == PARITY_ODD);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit oversampling counter and mid-bit three-sample majority vote.
// The vote is presented in the cycle edge_cnt = P/2+1, using the live synchronized line as the third sample.
module uart_rx_sampler #(
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  rx_s,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  cnt_en,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic                  bit_done,
  output logic                  sample_valid,
  output logic                  sampled_bit
);
  import uart_pkg::*;

  logic [PRESCALE_W-1:0] edge_cnt_r;
  logic [PRESCALE_W-1:0] half_s;
  logic [PRESCALE_W-1:0] last_s;
  logic                  samp0_r;
  logic                  samp1_r;

  assign half_s = {1'b0, prescale[PRESCALE_W-1:1]};
  assign last_s = prescale - PRESCALE_W'(1);

  // Oversample counter: wraps at each bit boundary, cleared whenever the frame is not running.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt_r <= {PRESCALE_W{1'b0}};
    end else if (cnt_en) begin
      if (edge_cnt_r == last_s) begin
        edge_cnt_r <= {PRESCALE_W{1'b0}};
      end else begin
        edge_cnt_r <= edge_cnt_r + PRESCALE_W'(1);
      end
    end else begin
      edge_cnt_r <= {PRESCALE_W{1'b0}};
    end
  end

  // Capture the two samples that precede the vote cycle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      samp0_r <= 1'b1;
      samp1_r <= 1'b1;
    end else if (edge_cnt_r == half_s - PRESCALE_W'(1)) begin
      samp0_r <= rx_s;
      samp1_r <= samp1_r;
    end else if (edge_cnt_r == half_s) begin
      samp0_r <= samp0_r;
      samp1_r <= rx_s;
    end else begin
      samp0_r <= samp0_r;
      samp1_r <= samp1_r;
    end
  end

  assign edge_cnt     = edge_cnt_r;
  assign bit_done     = (edge_cnt_r == last_s);
  assign sample_valid = (edge_cnt_r == half_s + PRESCALE_W'(1));
  assign sampled_bit  = majority3(samp0_r, samp1_r, rx_s);

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: synchronizes RX_IN, frames start/data/parity/stop bits and
// reports each frame with exactly one of Data_Valid, Parity_Error or Stop_Error.
module uart_rx_core #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  Parity_Enable,
  input  logic                  Parity_Type,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  Parity_Error,
  output logic                  Stop_Error
);
  import uart_pkg::*;

  localparam int              BCW      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BCW-1:0]  LAST_BIT = BCW'(DATA_WIDTH - 1);

  logic                  rx_meta_r;
  logic                  rx_sync_r;
  logic                  rx_s;
  rx_state_e             state_r;
  logic [PRESCALE_W-1:0] prescale_r;
  logic                  par_en_r;
  logic                  par_type_r;
  logic [BCW-1:0]        bit_cnt_r;
  logic [DATA_WIDTH-1:0] shift_r;
  logic                  par_err_r;

  logic                  cnt_en_s;
  logic [PRESCALE_W-1:0] edge_cnt_s;
  logic                  bit_done_s;
  logic                  sample_valid_s;
  logic                  sampled_bit_s;

  function automatic logic expected_parity(input logic [DATA_WIDTH-1:0] d, input logic ptype);
    return parity_expect(^d, ptype);
  endfunction

  // Two-flop synchronizer for the asynchronous serial line (idles high).
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= RX_IN;
      rx_sync_r <= rx_meta_r;
    end
  end

  assign rx_s = rx_sync_r;

  // The oversample counter runs exactly while the frame stays out of IDLE next cycle.
  always_comb begin
    cnt_en_s = 1'b0;
    case (state_r)
      RX_IDLE:   cnt_en_s = !rx_s && (edge_cnt_s == {PRESCALE_W{1'b0}});
      RX_START:  cnt_en_s = !(sample_valid_s && sampled_bit_s);
      RX_DATA:   cnt_en_s = 1'b1;
      RX_PARITY: cnt_en_s = 1'b1;
      RX_STOP:   cnt_en_s = !sample_valid_s;
      default:   cnt_en_s = 1'b0;
    endcase
  end

  uart_rx_sampler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_sampler (
    .CLK          (CLK),
    .RST          (RST),
    .rx_s         (rx_s),
    .prescale     (prescale_r),
    .cnt_en       (cnt_en_s),
    .edge_cnt     (edge_cnt_s),
    .bit_done     (bit_done_s),
    .sample_valid (sample_valid_s),
    .sampled_bit  (sampled_bit_s)
  );

  // Frame FSM with bit counter, shift register, parity tracking and registered strobes.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r      <= RX_IDLE;
      prescale_r   <= PRESCALE_W'(PRESCALE_8);
      par_en_r     <= 1'b0;
      par_type_r   <= PARITY_EVEN;
      bit_cnt_r    <= {BCW{1'b0}};
      shift_r      <= {DATA_WIDTH{1'b0}};
      par_err_r    <= 1'b0;
      P_DATA       <= {DATA_WIDTH{1'b0}};
      Data_Valid   <= 1'b0;
      Parity_Error <= 1'b0;
      Stop_Error   <= 1'b0;
    end else begin
      Data_Valid   <= 1'b0;
      Parity_Error <= 1'b0;
      Stop_Error   <= 1'b0;
      case (state_r)
        RX_IDLE: begin
          if (!rx_s && (edge_cnt_s == {PRESCALE_W{1'b0}})) begin
            state_r    <= RX_START;
            prescale_r <= Prescale;
            par_en_r   <= Parity_Enable;
            par_type_r <= Parity_Type;
            bit_cnt_r  <= {BCW{1'b0}};
            par_err_r  <= 1'b0;
          end
        end
        RX_START: begin
          // A high vote means the falling edge was only a glitch.
          if (sample_valid_s && sampled_bit_s) begin
            state_r <= RX_IDLE;
          end else if (bit_done_s) begin
            state_r <= RX_DATA;
          end
        end
        RX_DATA: begin
          if (sample_valid_s) begin
            shift_r <= {sampled_bit_s, shift_r[DATA_WIDTH-1:1]};
          end
          if (bit_done_s) begin
            if (bit_cnt_r == LAST_BIT) begin
              bit_cnt_r <= {BCW{1'b0}};
              state_r   <= par_en_r ? RX_PARITY : RX_STOP;
            end else begin
              bit_cnt_r <= bit_cnt_r + BCW'(1);
            end
          end
        end
        RX_PARITY: begin
          if (sample_valid_s) begin
            par_err_r <= (sampled_bit_s != expected_parity(shift_r, par_type_r));
          end
          if (bit_done_s) begin
            state_r <= RX_STOP;
          end
        end
        RX_STOP: begin
          // Leave at the vote so the next start edge can be caught immediately.
          if (sample_valid_s) begin
            state_r <= RX_IDLE;
            if (!sampled_bit_s) begin
              Stop_Error <= 1'b1;
            end else if (par_err_r) begin
              Parity_Error <= 1'b1;
            end else begin
              Data_Valid <= 1'b1;
              P_DATA     <= shift_r;
            end
          end
        end
        default: begin
          state_r <= RX_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: frames are driven serially, the expected
// outcome of each is queued, and a negedge monitor pops and compares every strobe.
module tb_uart_rx_core;

  logic       CLK;
  logic       RST;
  logic       RX_IN;
  logic [5:0] Prescale;
  logic       Parity_Enable;
  logic       Parity_Type;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       Parity_Error;
  logic       Stop_Error;

  typedef struct {
    logic [2:0] kind;     // {stop, parity, valid} one-hot
    logic [7:0] data;
    int         exp_cyc;  // negative: latency not checked
  } sb_entry_t;

  sb_entry_t  sb_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  logic [7:0] last_good = 8'h00;

  logic [2:0] strb_m;
  logic [2:0] prev_strb_m = 3'b000;
  sb_entry_t  ent_m;

  uart_rx_core dut (
    .CLK           (CLK),
    .RST           (RST),
    .RX_IN         (RX_IN),
    .Prescale      (Prescale),
    .Parity_Enable (Parity_Enable),
    .Parity_Type   (Parity_Type),
    .P_DATA        (P_DATA),
    .Data_Valid    (Data_Valid),
    .Parity_Error  (Parity_Error),
    .Stop_Error    (Stop_Error)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic drive_bit(input logic b, input int n);
    RX_IN = b;
    wait_cyc(n);
  endtask

  // Called at posedge+1; queues the modelled outcome, then drives the frame.
  task automatic send_frame(input logic [7:0] d, input logic par_bit, input logic stop_bit,
                            input int bit_cyc, input bit lat_chk);
    sb_entry_t e;
    int        p;
    logic      par_ok;
    p      = int'(Prescale);
    par_ok = !Parity_Enable || (par_bit == ((^d) ^ Parity_Type));
    if (!stop_bit) begin
      e.kind = 3'b100;
    end else if (!par_ok) begin
      e.kind = 3'b010;
    end else begin
      e.kind    = 3'b001;
      last_good = d;
    end
    e.data = last_good;
    RX_IN  = 1'b0;
    // 2 sync cycles + start/data bits + half bit to the vote + 1 output register
    e.exp_cyc = lat_chk ? (cyc + 2 + 9 * p + p / 2 + 2 + (Parity_Enable ? p : 0)) : -1;
    sb_q.push_back(e);
    wait_cyc(bit_cyc);
    for (int i = 0; i < 8; i++) drive_bit(d[i], bit_cyc);
    if (Parity_Enable) drive_bit(par_bit, bit_cyc);
    drive_bit(stop_bit, bit_cyc);
    RX_IN = 1'b1;
  endtask

  // Scoreboard monitor: every strobe must match the head of the queue.
  always @(negedge CLK) begin
    strb_m = {Stop_Error, Parity_Error, Data_Valid};
    if (prev_strb_m != 3'b000) check_val("one_cycle_pulse", {29'd0, strb_m}, 32'd0);
    if (strb_m != 3'b000) begin
      if (sb_q.size() == 0) begin
        check_val("unexpected_strobe", {29'd0, strb_m}, 32'd0);
      end else begin
        ent_m = sb_q.pop_front();
        check_val("strobe_kind", {29'd0, strb_m}, {29'd0, ent_m.kind});
        check_val("p_data", {24'd0, P_DATA}, {24'd0, ent_m.data});
        if (ent_m.exp_cyc >= 0) check_val("latency", cyc, ent_m.exp_cyc);
      end
    end
    prev_strb_m = strb_m;
  end

  task automatic check_reset_outputs(input string phase);
    check_val({phase, "_p_data"}, {24'd0, P_DATA}, 32'd0);
    check_val({phase, "_strobes"}, {29'd0, Stop_Error, Parity_Error, Data_Valid}, 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, pending=%0d expected 0", sb_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    RST           = 1'b0;
    RX_IN         = 1'b1;
    Prescale      = 6'd8;
    Parity_Enable = 1'b0;
    Parity_Type   = 1'b0;
    wait_cyc(3);
    @(negedge CLK);
    check_reset_outputs("reset");
    @(posedge CLK); #1;
    RST = 1'b1;
    wait_cyc(5);

    // P=8, no parity, 0xA5 with latency check
    send_frame(8'hA5, 1'b0, 1'b1, 8, 1'b1);
    wait_cyc(20);
    check_val("pending_a5", sb_q.size(), 32'd0);

    // P=16, even parity: good frame then parity mismatch
    Prescale      = 6'd16;
    Parity_Enable = 1'b1;
    Parity_Type   = 1'b0;
    send_frame(8'h3C, 1'b0, 1'b1, 16, 1'b1);
    wait_cyc(10);
    send_frame(8'h3C, 1'b1, 1'b1, 16, 1'b1);
    wait_cyc(30);
    check_val("pending_par", sb_q.size(), 32'd0);

    // P=8, odd parity, good parity but stop bit low
    Prescale    = 6'd8;
    Parity_Type = 1'b1;
    send_frame(8'h00, 1'b1, 1'b0, 8, 1'b1);
    wait_cyc(30);
    check_val("pending_stop", sb_q.size(), 32'd0);

    // Two-cycle glitch, then a valid frame
    Parity_Enable = 1'b0;
    RX_IN = 1'b0;
    wait_cyc(2);
    RX_IN = 1'b1;
    wait_cyc(20);
    check_val("glitch_no_strobe", sb_q.size(), 32'd0);
    send_frame(8'h5A, 1'b0, 1'b1, 8, 1'b1);
    wait_cyc(20);
    check_val("pending_5a", sb_q.size(), 32'd0);

    // P=32, back-to-back with bits 33 cycles long (~3% slow)
    Prescale = 6'd32;
    send_frame(8'h55, 1'b0, 1'b1, 33, 1'b0);
    send_frame(8'hAA, 1'b0, 1'b1, 33, 1'b0);
    wait_cyc(40);
    check_val("pending_b2b", sb_q.size(), 32'd0);

    // Reset mid-DATA, then receive 0x81
    Prescale = 6'd8;
    drive_bit(1'b0, 8);
    drive_bit(1'b0, 8);
    drive_bit(1'b1, 8);
    drive_bit(1'b0, 4);
    RST   = 1'b0;
    RX_IN = 1'b1;
    last_good = 8'h00;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check_reset_outputs("midrst");
    end
    @(posedge CLK); #1;
    RST = 1'b1;
    wait_cyc(100);
    check_val("abort_no_strobe", sb_q.size(), 32'd0);
    send_frame(8'h81, 1'b0, 1'b1, 8, 1'b1);
    wait_cyc(20);
    check_val("pending_81", sb_q.size(), 32'd0);
    check_val("p_data_hold", {24'd0, P_DATA}, {24'd0, last_good});

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
UART receiver, the counterpart of the team's TX path. It oversamples the serial line, finds the start bit and majority-votes the middle of each bit. It then deserializes LSB-first data, checks the optional parity bit and the stop bit, and presents the byte with a one-cycle valid strobe. It sits between the pad-side RX line and the system-side byte consumer, clocked by the oversampling clock (Prescale x baud).

Parameters:
DATA_WIDTH, 8, number of data bits per frame
PRESCALE_W, 6, width of Prescale input; legal Prescale values are 8, 16, 32

Ports:
CLK  in  1  oversampling clock
RST  in  1  asynchronous active-low reset
RX_IN  in  1  serial line, idle high, asynchronous to CLK
Prescale  in  PRESCALE_W  oversamples per bit (8/16/32)
Parity_Enable  in  1  1 = frame carries a parity bit after the data
Parity_Type  in  1  0 = even, 1 = odd
P_DATA  out  DATA_WIDTH  last correctly received byte
Data_Valid  out  1  one-cycle pulse: P_DATA updated with a good frame
Parity_Error  out  1  one-cycle pulse: frame rejected, parity mismatch
Stop_Error  out  1  one-cycle pulse: frame rejected, stop bit sampled 0

Behaviour:
- Reset (async, RST=0):
  - State = IDLE, synchronizer flops = 1, counters = 0.
  - P_DATA = 0; Data_Valid, Parity_Error and Stop_Error = 0.
  - Reset mid-frame aborts the frame silently with no strobes.
- RX_IN passes through a 2-flop synchronizer (reset value 1). All references below are to the synchronized value rx_s.
- States: IDLE, START, DATA, PARITY, STOP.
- Counters:
  - edge_cnt runs 0..Prescale-1 within each bit and wraps to 0 at a bit boundary.
  - bit_cnt runs 0..DATA_WIDTH-1 in DATA.
- IDLE -> START on the first cycle rx_s=0. That cycle is edge_cnt=0 of the start bit (cycle 0 of the frame).
- Prescale, Parity_Enable and Parity_Type are latched on the IDLE->START transition. Changes mid-frame are ignored.
- Sampling: samples are taken at edge_cnt = P/2-1, P/2 and P/2+1. In the cycle edge_cnt = P/2+1, the bit value = majority of the three samples.
- START:
  - Voted value 1 = glitch: go to IDLE immediately, no strobes.
  - Voted value 0: remain until edge_cnt = P-1, then go to DATA.
- DATA:
  - Each voted bit is shifted in LSB-first.
  - After bit DATA_WIDTH-1 completes (edge_cnt = P-1), go to PARITY if Parity_Enable, else to STOP.
- PARITY:
  - Expected bit = XOR of the data bits, inverted when Parity_Type = 1.
  - A mismatch is recorded internally.
  - At edge_cnt = P-1, go to STOP.
- STOP: at the vote cycle (edge_cnt = P/2+1) go directly to IDLE; the remaining half bit is not waited for. In the following cycle exactly one of these is 1 for one cycle:
  - Stop_Error, if the stop vote = 0. Stop_Error takes precedence over Parity_Error.
  - Parity_Error, if the stop bit is good and parity mismatched.
  - Data_Valid, otherwise. P_DATA is loaded in that same cycle.
- P_DATA holds its value across rejected frames and idle time.
- Latency:
  - With parity off, the stop vote is at cycle (1+DATA_WIDTH)*P + P/2+1 and Data_Valid at the cycle after.
  - With parity on, add P.
  - For P=8, no parity: Data_Valid at cycle 78.
- Back-to-back frames: a new start may be detected in IDLE on the very cycle after the STOP vote. The early exit absorbs up to ~P/2 of baud mismatch.
- Break (line held low): reported as Stop_Error, then IDLE. While the line stays low, START is re-entered each frame time, and each such frame ends in Stop_Error.
- Prescale values other than 8/16/32: behaviour undefined, not checked.

Decomposition:
- Package uart_pkg: RX state encoding (3-bit, IDLE=0..STOP=4), parity type constants (EVEN=0, ODD=1), legal prescale constants. The TX path shares this package.
- Sub-module uart_rx_sampler: edge_cnt, the three sample registers and the majority vote. It outputs edge_cnt, bit_done (edge_cnt = P-1) and sample_valid/sampled_bit (edge_cnt = P/2+1).
- The FSM, bit counter, shift register, parity check and output registers stay in uart_rx_core.

Test Plan:
- P=8, parity off, send 0xA5 with stop=1 -> Data_Valid=1 for exactly one cycle, at cycle 78 after the first synchronized low; P_DATA=0xA5; no error strobes.
- P=16, even parity, send 0x3C with parity=0 then 0x3C with parity=1 -> first frame Data_Valid, P_DATA=0x3C; second frame Parity_Error pulse, Data_Valid=0, P_DATA stays 0x3C.
- P=8, odd parity, send 0x00 with parity=1 and stop=0 -> Stop_Error pulse only, no Parity_Error, P_DATA unchanged.
- P=8, RX_IN low for 2 cycles then high -> START entered, vote=1, return to IDLE, no strobes; a following valid 0x5A frame is received correctly.
- P=32, frames 0x55 and 0xAA back-to-back with no idle gap, baud 3% slow -> two Data_Valid pulses, P_DATA = 0x55 then 0xAA.
- Assert RST low mid-DATA of a frame, then send 0x81 -> no strobes from the aborted frame; all outputs 0 during reset; 0x81 received with Data_Valid.
